if_id_stage: RTL

IF_ID_STAGE -- requirements
Module: if_id_stage

---
 rtl/if_id_stage_pkg.sv | 33 +++
 rtl/if_id_stage_ins_field_decode.sv | 33 +++
 rtl/if_id_stage.sv | 126 ++++++++++++
 3 files changed

// File: rtl/if_id_stage_pkg.sv
// Shared types for the IF/ID pipeline buffer: occupancy states, the buffered
// fetch entry, and the MIPS-style instruction field positions.
package if_id_stage_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0] pc_next;
    logic [31:0] ins;
  } entry_t;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int RS_MSB     = 25;
  localparam int RS_LSB     = 21;
  localparam int RT_MSB     = 20;
  localparam int RT_LSB     = 16;
  localparam int RD_MSB     = 15;
  localparam int RD_LSB     = 11;
  localparam int SHAMT_MSB  = 10;
  localparam int SHAMT_LSB  = 6;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;
  localparam int JADDR_MSB  = 25;
  localparam int JADDR_LSB  = 0;

endpackage

// File: rtl/if_id_stage_ins_field_decode.sv
// Purely combinational split of an instruction word into its fields.
// Everything reads zero when the word is not valid.
module ins_field_decode
  import if_id_stage_pkg::*;
(
  input  logic        valid,
  input  logic [31:0] ins,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic [31:0] imm_sext,
  output logic [25:0] jaddr,
  output logic        nop
);

  logic [31:0] word;

  assign word     = valid ? ins : 32'h0000_0000;
  assign opcode   = word[OPCODE_MSB:OPCODE_LSB];
  assign rs       = word[RS_MSB:RS_LSB];
  assign rt       = word[RT_MSB:RT_LSB];
  assign rd       = word[RD_MSB:RD_LSB];
  assign shamt    = word[SHAMT_MSB:SHAMT_LSB];
  assign funct    = word[FUNCT_MSB:FUNCT_LSB];
  assign imm_sext = {{16{word[IMM_MSB]}}, word[IMM_MSB:IMM_LSB]};
  assign jaddr    = word[JADDR_MSB:JADDR_LSB];
  // An empty buffer presents a zero word but is not a NOP.
  assign nop      = valid && (ins == 32'h0000_0000);

endmodule

// File: rtl/if_id_stage.sv
// Two-entry in-order IF/ID buffer with flush, flush statistics and decode.
//
//   state    | meaning
//   ST_EMPTY | no valid entry, decode sees zeros
//   ST_ONE   | slot 0 holds the head entry
//   ST_FULL  | slot 0 is head, slot 1 is next; fetch is stalled
module if_id_stage
  import if_id_stage_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pc_next,
  input  logic [31:0] in_ins,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc_next,
  output logic [31:0] out_ins,
  output logic [5:0]  out_opcode,
  output logic [4:0]  out_rs,
  output logic [4:0]  out_rt,
  output logic [4:0]  out_rd,
  output logic [4:0]  out_shamt,
  output logic [5:0]  out_funct,
  output logic [31:0] out_imm_sext,
  output logic [25:0] out_jaddr,
  output logic        out_nop,
  output logic [7:0]  flush_cnt
);

  state_e                 state_q, state_d;
  entry_t [DEPTH-1:0]     slot_q, slot_d;
  logic   [7:0]           flush_cnt_q, flush_cnt_d;

  entry_t in_entry;
  entry_t head;
  logic   push;
  logic   pop;

  assign in_entry  = '{pc_next: in_pc_next, ins: in_ins};
  assign in_ready  = (state_q != ST_FULL) && rst_n;
  assign out_valid = (state_q != ST_EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    flush_cnt_d = flush_cnt_q;
    if (flush) begin
      // Flush wins over any coincident push or pop.
      state_d = ST_EMPTY;
      slot_d  = '0;
      if ((state_q != ST_EMPTY) && (flush_cnt_q != 8'hFF)) begin
        flush_cnt_d = flush_cnt_q + 8'd1;
      end
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (push) begin
            slot_d[0] = in_entry;
            state_d   = ST_ONE;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            slot_d[0] = in_entry;
          end else if (push) begin
            slot_d[1] = in_entry;
            state_d   = ST_FULL;
          end else if (pop) begin
            slot_d[0] = '0;
            state_d   = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (pop) begin
            slot_d[0] = slot_q[1];
            slot_d[1] = '0;
            state_d   = ST_ONE;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          slot_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      slot_q      <= '0;
      flush_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign head        = out_valid ? slot_q[0] : '0;
  assign out_pc_next = head.pc_next;
  assign out_ins     = head.ins;
  assign flush_cnt   = flush_cnt_q;

  ins_field_decode u_decode (
    .valid    (out_valid),
    .ins      (head.ins),
    .opcode   (out_opcode),
    .rs       (out_rs),
    .rt       (out_rt),
    .rd       (out_rd),
    .shamt    (out_shamt),
    .funct    (out_funct),
    .imm_sext (out_imm_sext),
    .jaddr    (out_jaddr),
    .nop      (out_nop)
  );

endmodule
